seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Programmable serial bit-pattern detector, successor to the fixed 4-state "1101" Mealy detector.
//   Pattern bits, pattern length (1..MAX_LEN) and overlap mode are set at run time.
//   Adds an input-valid qualifier, a synchronous restart, a registered match copy and a saturating match counter.
//   Sits on a 1-bit serial data stream; match feeds downstream framing/alarm logic.
// PARAMETERS
//   MAX_LEN  8  maximum pattern length in bits (>=2)
//   CNT_W    8  width of match_cnt
//   LEN_W    $clog2(MAX_LEN+1)  width of cfg_len (derived, not overridden)
// PORTS
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous reset, active-low
//   en           in   1        din valid this cycle
//   din          in   1        serial data bit
//   restart      in   1        sync: discard history, return to IDLE
//   cfg_pattern  in   MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
//   cfg_len      in   LEN_W    pattern length; 0 = detector disabled; >MAX_LEN is clamped to MAX_LEN
//   cfg_overlap  in   1        1 = overlapping matches allowed; 0 = history cleared after each match
//   clr_cnt      in   1        sync clear of match_cnt
//   match        out  1        combinational Mealy match for the current (en,din)
//   match_q      out  1        match registered one cycle later
//   match_cnt    out  CNT_W    saturating count of matches
//   armed        out  1        history holds >= L-1 valid bits (next valid bit can match)
// BEHAVIOUR
// - Reset (rst_n=0, async): hist=0, fill=0, state IDLE, match_q=0, match_cnt=0, armed=0.
//   match is then 0 regardless of din.
// - L = min(cfg_len, MAX_LEN).
// - hist[MAX_LEN-1:0]: shift register of valid bits, newest in bit 0. Shifts only when en=1.
// - fill: count of valid bits in hist, saturating at MAX_LEN.
// - State view of fill:
//   - IDLE: fill=0.
//   - FILL: 0 < fill < L-1.
//   - ARMED: fill >= L-1.
//   - armed = (state==ARMED) && (L!=0).
//   - With L=1, IDLE counts as ARMED.
// - match = en && L!=0 && fill>=L-1 && {hist[L-2:0],din} == cfg_pattern[L-1:0].
//   - For L=1 the comparison is din == cfg_pattern[0].
//   - Zero latency: same cycle as the last pattern bit, as in the predecessor.
// - On a clock edge with en=1:
//   - hist <= {hist[MAX_LEN-2:0],din}.
//   - If match && !cfg_overlap: fill <= 0. The matching bit is not reused.
//   - Otherwise fill <= sat(fill+1).
// - en=0: hist and fill hold; match=0.
// - restart=1: hist<=0 and fill<=0, with priority over en. match is forced to 0 that cycle.
// - match_q <= match every cycle.
// - match_cnt:
//   - clr_cnt=1 -> 0. Clear wins over a simultaneous match.
//   - Else match=1 -> +1, saturating at 2^CNT_W-1 (no wrap).
// - Config changes take effect immediately on match; hist is not rewritten.
//   - Software asserts restart after changing cfg_len/cfg_pattern if stale history must not match.
// - cfg_overlap toggled mid-stream affects only the next match decision.
// - Reset mid-pattern: the partial pattern is lost; a full L new valid bits are needed before the next match.
// TESTING
// - T1: L=4, pat=4'b1101, overlap=1, en=1, din 1,1,0,1,1,0,1
//   -> match=1 on bits 4 and 7 only; match_q one cycle later; match_cnt=2.
// - T2: same stream, overlap=0
//   -> match on bit 4 only; match_cnt=1; armed drops to 0 the cycle after bit 4.
// - T3: L=4, pat=1101, stream 1,1,0,1 with en=0 gaps (and din toggling) between each bit
//   -> exactly one match, on the 4th valid bit; match=0 in every en=0 cycle.
// - T4: MAX_LEN=8, L=8, pat=8'hA5, stream 1010_0101 then 0100_1010_0101
//   -> matches at bits 8 and 20.
// - T4 (cont.): repeat with L=9 -> clamped to 8, same result.
// - T4 (cont.): L=0 -> no match ever.
// - T5: CNT_W=2, L=1, pat=1, din=1 for 5 valid cycles -> match_cnt 1,2,3,3,3.
// - T5 (cont.): clr_cnt asserted with match -> match_cnt=0.
// - T6: L=4, pat=1101, send 1,1,0 then pulse rst_n low mid-cycle, then 1
//   -> outputs zero immediately during reset, no match on that 1.
// - T6 (cont.): 1,1,0,1 afterwards -> match.
// - T6 (cont.): same sequence with restart pulse instead of reset -> same result.

Source files
------------

// File: rtl/seq_detect_param.sv
// Programmable serial bit-pattern detector.
// Compares the most recent valid bits of a 1-bit stream against a run-time
// pattern of length 1..MAX_LEN. The match output is Mealy: it is raised in the
// same cycle as the last pattern bit. A registered copy and a saturating
// match counter are also provided.
module seq_detect_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din,
  input  logic               restart,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  // Coarse view of the history fill level relative to the active length.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bit mask with the low 'len' bits set; selects the active pattern window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Fill level increment that sticks at MAX_LEN.
  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
    if (f >= LEN_MAX_V) begin
      return LEN_MAX_V;
    end else begin
      return f + LEN_ONE;
    end
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return c + CNT_ONE;
    end
  endfunction

  // Only the newest MAX_LEN-1 history bits can ever take part in a compare
  // (the current din supplies the last pattern bit), so the oldest bit of the
  // conceptual MAX_LEN-bit shift register is not stored.
  logic [MAX_LEN-2:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               match_q_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [LEN_W-1:0]   len_s;
  logic [LEN_W-1:0]   len_m1_s;
  logic               len_nz_s;
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               cmp_ok_s;
  state_t             state_s;
  logic               armed_s;
  logic               match_s;

  // Clamp the configured length and derive the compare window and mask.
  always_comb begin
    if (cfg_len > LEN_MAX_V) begin
      len_s = LEN_MAX_V;
    end else begin
      len_s = cfg_len;
    end
    len_nz_s = (len_s != LEN_ZERO);
    if (len_nz_s) begin
      len_m1_s = len_s - LEN_ONE;
    end else begin
      len_m1_s = LEN_ZERO;
    end
    window_s = {hist_r, din};
    mask_s   = len_mask(len_s);
    cmp_ok_s = (((window_s ^ cfg_pattern) & mask_s) == {MAX_LEN{1'b0}});
  end

  // Decode the fill level into IDLE / FILL / ARMED against the live length.
  always_comb begin
    if (fill_r == LEN_ZERO) begin
      state_s = ST_IDLE;
    end else if (len_nz_s && (fill_r >= len_m1_s)) begin
      state_s = ST_ARMED;
    end else begin
      state_s = ST_FILL;
    end
  end

  // Armed when the next valid bit could complete a match; a 1-bit pattern
  // needs no history, so IDLE is armed in that case. Held low during reset.
  always_comb begin
    if (rst_n && len_nz_s) begin
      armed_s = (state_s == ST_ARMED) ||
                ((state_s == ST_IDLE) && (len_m1_s == LEN_ZERO));
    end else begin
      armed_s = 1'b0;
    end
  end

  // Mealy match: valid bit, enabled detector, enough history, window equal.
  always_comb begin
    if (rst_n && en && !restart) begin
      match_s = armed_s && cmp_ok_s;
    end else begin
      match_s = 1'b0;
    end
  end

  // History shift register and fill level; restart outranks a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= LEN_ZERO;
    end else if (restart) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= LEN_ZERO;
    end else if (en) begin
      hist_r <= window_s[MAX_LEN-2:0];
      if (match_s && !cfg_overlap) begin
        fill_r <= LEN_ZERO;
      end else begin
        fill_r <= fill_inc(fill_r);
      end
    end
  end

  // Registered copy of the match decision, one cycle behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q_r <= 1'b0;
    end else begin
      match_q_r <= match_s;
    end
  end

  // Saturating match counter; a clear beats a coincident match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr_cnt) begin
      cnt_r <= CNT_ZERO;
    end else if (match_s) begin
      cnt_r <= cnt_inc(cnt_r);
    end
  end

  assign match     = match_s;
  assign match_q   = match_q_r;
  assign match_cnt = cnt_r;
  assign armed     = armed_s;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed vector table, hand
// sequences for reset/restart/length corner cases, and randomized traffic
// checked against a queue-based reference model.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = 255;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               din;
  logic               restart;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_cnt;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .restart(restart),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .match(match), .match_q(match_q),
    .match_cnt(match_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Reference model state: valid bits since the last history clear (oldest first).
  bit seg[$];
  int exp_cnt = 0;
  bit exp_q   = 1'b0;

  logic dm, da;

  typedef struct {
    bit seg_start;
    bit ovl;
    bit e;
    bit d;
    bit xm;
    bit xa;
    int xc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, name, act, exp, $time);
    end
  endtask

  function automatic int eff_len();
    int l;
    l = int'(cfg_len);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  function automatic bit m_armed();
    int l;
    l = eff_len();
    return (l != 0) && (seg.size() >= l - 1);
  endfunction

  function automatic bit m_match();
    int l;
    int n;
    l = eff_len();
    n = seg.size();
    if (!en || restart || l == 0) return 1'b0;
    if (n < l - 1) return 1'b0;
    for (int j = 0; j < l - 1; j++) begin
      if (seg[n - (l - 1) + j] != cfg_pattern[l - 1 - j]) return 1'b0;
    end
    return din == cfg_pattern[0];
  endfunction

  task automatic m_update(input bit m);
    exp_q = m;
    if (clr_cnt) exp_cnt = 0;
    else if (m && exp_cnt < CNT_MAX) exp_cnt++;
    if (restart) begin
      seg.delete();
    end else if (en) begin
      if (m && !cfg_overlap) begin
        seg.delete();
      end else begin
        seg.push_back(din);
        if (seg.size() > MAX_LEN) void'(seg.pop_front());
      end
    end
  endtask

  task automatic m_reset();
    seg.delete();
    exp_cnt = 0;
    exp_q   = 1'b0;
  endtask

  // One clock cycle: drive, check Mealy outputs mid-cycle, clock, check registers.
  task automatic step(input bit e, input bit d, input bit r, input bit c,
                      output logic dut_m, output logic dut_a);
    bit m;
    en = e; din = d; restart = r; clr_cnt = c;
    @(negedge clk);
    m = m_match();
    dut_m = match;
    dut_a = armed;
    chk("match", 32'(match), 32'(m));
    chk("armed", 32'(armed), 32'(m_armed()));
    @(posedge clk);
    #1;
    m_update(m);
    chk("match_q", 32'(match_q), 32'(exp_q));
    chk("match_cnt", 32'(match_cnt), 32'(exp_cnt));
  endtask

  function automatic vec_t mk(bit s, bit o, bit e, bit d, bit xm, bit xa, int xc);
    vec_t v;
    v.seg_start = s; v.ovl = o; v.e = e; v.d = d; v.xm = xm; v.xa = xa; v.xc = xc;
    return v;
  endfunction

  int lens[3] = '{8, 9, 0};
  logic [19:0] t4_stream;
  int seen;

  initial begin
    // Reset state
    rst_n = 1'b0; en = 1'b0; din = 1'b0; restart = 1'b0; clr_cnt = 1'b0;
    cfg_len = 4'd4; cfg_pattern = 8'h0D; cfg_overlap = 1'b1;
    #3;
    phase = "reset";
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_match_q", 32'(match_q), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    cfg_len = 4'd1; cfg_pattern = 8'h01; en = 1'b1; din = 1'b1;
    #1;
    chk("rst_match_l1", 32'(match), 32'd0);
    chk("rst_armed_l1", 32'(armed), 32'd0);
    en = 1'b0; din = 1'b0; cfg_len = 4'd4; cfg_pattern = 8'h0D;
    @(negedge clk); #1 rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;

    // Directed table: L=4, pattern 1101 (T1 overlap, T2 non-overlap, T3 en gaps)
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 2));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1));
    phase = "table";
    cfg_len = 4'd4; cfg_pattern = 8'h0D;
    for (int i = 0; i < tbl.size(); i++) begin
      cfg_overlap = tbl[i].ovl;
      if (tbl[i].seg_start) step(1'b0, 1'b0, 1'b1, 1'b1, dm, da);
      step(tbl[i].e, tbl[i].d, 1'b0, 1'b0, dm, da);
      chk($sformatf("tbl%0d_match", i), 32'(dm), 32'(tbl[i].xm));
      chk($sformatf("tbl%0d_armed", i), 32'(da), 32'(tbl[i].xa));
      chk($sformatf("tbl%0d_cnt", i), 32'(match_cnt), 32'(tbl[i].xc));
    end

    // T4: 8-bit pattern A5, non-overlapping, at L=8, clamped L=9, disabled L=0
    phase = "t4";
    t4_stream = 20'b1010_0101_0100_1010_0101;
    cfg_pattern = 8'hA5; cfg_overlap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_len = LEN_W'(lens[k]);
      step(1'b0, 1'b0, 1'b1, 1'b1, dm, da);
      for (int i = 0; i < 20; i++) begin
        step(1'b1, t4_stream[19 - i], 1'b0, 1'b0, dm, da);
        chk($sformatf("t4_len%0d_bit%0d", lens[k], i + 1), 32'(dm),
            32'((lens[k] != 0) && (i == 7 || i == 19)));
        if (lens[k] == 0) chk("t4_len0_armed", 32'(da), 32'd0);
      end
      chk($sformatf("t4_len%0d_cnt", lens[k]), 32'(match_cnt), (lens[k] != 0) ? 32'd2 : 32'd0);
    end

    // T5: L=1 pattern 1, counter saturation and clear-over-match
    phase = "t5";
    cfg_len = 4'd1; cfg_pattern = 8'h01; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, dm, da);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
      chk("t5_cnt", 32'(match_cnt), 32'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
    end
    chk("t5_armed_l1", 32'(da), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, dm, da);
    chk("t5_clr_match", 32'(dm), 32'd1);
    chk("t5_clr_cnt", 32'(match_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    chk("t5_din0", 32'(dm), 32'd0);

    // T6: async reset mid-pattern, then the same with a restart pulse
    phase = "t6";
    cfg_len = 4'd4; cfg_pattern = 8'h0D; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    chk("t6_pre_match", 32'(dm), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    en = 1'b1; din = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_match", 32'(match), 32'd0);
    chk("t6_rst_match_q", 32'(match_q), 32'd0);
    chk("t6_rst_cnt", 32'(match_cnt), 32'd0);
    chk("t6_rst_armed", 32'(armed), 32'd0);
    en = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    chk("t6_after_rst_one", 32'(dm), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    chk("t6_after_rst_match", 32'(dm), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b1, 1'b0, dm, da);
    chk("t6_restart_cycle", 32'(dm), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    chk("t6_after_restart_one", 32'(dm), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b0, 1'b0, 1'b0, dm, da);
    step(1'b1, 1'b1, 1'b0, 1'b0, dm, da);
    chk("t6_after_restart_match", 32'(dm), 32'd1);

    // Randomized traffic against the reference model
    phase = "random";
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 3) == 0) cfg_len = LEN_W'($urandom_range(0, 15));
        else cfg_len = LEN_W'($urandom_range(1, 4));
        cfg_pattern = 8'($urandom);
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) == 0), dm, da);
      if (dm === 1'b1) seen++;
    end
    chk("random_activity", 32'(seen > 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
